// File: rtl/vga_pkg.sv
// Shared VGA constants and types: screen geometry, player sprite geometry,
// the 12-bit colour type and the bundle of timing fields that travel with every pixel.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam int PLAYER_W      = 48;
    localparam int PLAYER_H      = 64;
    localparam int PLAYER_ADDR_W = 12;

    typedef logic [11:0] rgb_t;

    localparam rgb_t TRANSPARENT_RGB = 12'h0_f_0;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

    // Half-open span test on 12-bit values so start+len cannot wrap for 11-bit screen positions.
    function automatic logic in_span(input logic [11:0] pos, input logic [11:0] start,
                                     input logic [11:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between drawing stages: counters, syncs, blanks and colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// N-stage register pipe for the VGA timing fields, used to keep counters and syncs
// aligned with colour computed by a pipelined drawing stage.
module vga_delay
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  vga_timing_t timing_i,
    output vga_timing_t timing_o
);

    vga_timing_t pipe_q [N];

    // NOTE: the pipe is a handful of flops, not a RAM, so clearing every stage on reset is cheap and
    // keeps vga_out at 0 during reset; NOTE: non-blocking assignments here let every stage sample its
    // predecessor's old value on the same edge, which is what makes this a shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= timing_i;
            for (int i = 1; i < N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign timing_o = pipe_q[N-1];

endmodule

// File: rtl/draw_player.sv
// Overlays a SPRITE_W x SPRITE_H player sprite, read from an external ROM, at a frame-stable position.
// Build option DRAW_PLAYER_TRANSPARENT_EN: ROM pixels equal to TRANSPARENT_RGB let the background through.
module draw_player
    import vga_pkg::*;
#(
    parameter int SPRITE_W = PLAYER_W,
    parameter int SPRITE_H = PLAYER_H,
    parameter int ADDR_W   = PLAYER_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 vga_in,
    vga_if.out                vga_out,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic [ADDR_W-1:0] pixel_addr,
    input  rgb_t              rgb_pixel
);

    logic              vblnk_prev_q;
    logic [10:0]       xpos_q;
    logic [10:0]       ypos_q;
    logic              pos_valid_q;
    logic              vblnk_rise;

    logic              in_rect_d;
    logic [11:0]       dx;
    logic [11:0]       dy;
    logic [ADDR_W-1:0] pixel_addr_d;
    logic [ADDR_W-1:0] pixel_addr_q;
    rgb_t              rgb_s1_q;
    logic              in_rect_s1_q;
    logic              blank_s1_q;

    logic              use_sprite;
    rgb_t              rgb_out_d;
    rgb_t              rgb_out_q;

    vga_timing_t       timing_in;
    vga_timing_t       timing_out;

    // Position is only sampled as vertical blanking starts, so a frame never shows two positions.
    assign vblnk_rise = vga_in.vblnk & ~vblnk_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            pos_valid_q  <= 1'b0;
        end else begin
            vblnk_prev_q <= vga_in.vblnk;
            if (vblnk_rise) begin
                xpos_q      <= xpos;
                ypos_q      <= ypos;
                pos_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        dx           = {1'b0, vga_in.hcount} - {1'b0, xpos_q};
        dy           = {1'b0, vga_in.vcount} - {1'b0, ypos_q};
        in_rect_d    = pos_valid_q
                     && in_span({1'b0, vga_in.hcount}, {1'b0, xpos_q}, 12'(SPRITE_W))
                     && in_span({1'b0, vga_in.vcount}, {1'b0, ypos_q}, 12'(SPRITE_H));
        pixel_addr_d = pixel_addr_q;
        if (in_rect_d) begin
            pixel_addr_d = ADDR_W'(32'(dy) * SPRITE_W + 32'(dx));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr_q <= '0;
            rgb_s1_q     <= '0;
            in_rect_s1_q <= 1'b0;
            blank_s1_q   <= 1'b0;
        end else begin
            pixel_addr_q <= pixel_addr_d;
            rgb_s1_q     <= vga_in.rgb;
            in_rect_s1_q <= in_rect_d;
            blank_s1_q   <= vga_in.hblnk | vga_in.vblnk;
        end
    end

    assign pixel_addr = pixel_addr_q;

    // rgb_pixel belongs to the address issued last cycle, i.e. to the pixel now in stage 1.
    always_comb begin
`ifdef DRAW_PLAYER_TRANSPARENT_EN
        use_sprite = in_rect_s1_q && (rgb_pixel != TRANSPARENT_RGB);
`else
        use_sprite = in_rect_s1_q;
`endif
        rgb_out_d = rgb_s1_q;
        if (blank_s1_q) begin
            rgb_out_d = '0;
        end else if (use_sprite) begin
            rgb_out_d = rgb_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out_q <= '0;
        end else begin
            rgb_out_q <= rgb_out_d;
        end
    end

    assign timing_in = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                         hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                         hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk};

    vga_delay #(
        .N (2)
    ) u_timing_delay (
        .clk      (clk),
        .rst      (rst),
        .timing_i (timing_in),
        .timing_o (timing_out)
    );

    assign vga_out.hcount = timing_out.hcount;
    assign vga_out.vcount = timing_out.vcount;
    assign vga_out.hsync  = timing_out.hsync;
    assign vga_out.vsync  = timing_out.vsync;
    assign vga_out.hblnk  = timing_out.hblnk;
    assign vga_out.vblnk  = timing_out.vblnk;
    assign vga_out.rgb    = rgb_out_q;

endmodule

// File: tb/tb_draw_player.sv
// Scoreboard bench for draw_player: directed pixels push expected outputs, a monitor pops them
// two cycles later; reset behaviour is checked directly.
module tb_draw_player;
    import vga_pkg::*;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] xpos = 11'd100;
    logic [10:0] ypos = 11'd50;
    logic [11:0] pixel_addr;
    rgb_t        rgb_pixel;

    vga_if vin();
    vga_if vout();

    draw_player dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (vin),
        .vga_out    (vout),
        .xpos       (xpos),
        .ypos       (ypos),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel)
    );

    always #5 clk = ~clk;

    // ROM model: data follows the registered address; offset (5,5) = address 245 holds the key colour.
    always_comb rgb_pixel = (pixel_addr == 12'd245) ? 12'h0f0 : pixel_addr;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag_cnt = 0;
    pix_t exp_q[$];
    int   tag_q[$];
    logic drv_valid = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] out_word();
        return 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
    endfunction

    always @(posedge clk) begin
        v2 <= v1;
        v1 <= drv_valid;
    end

    // Monitor: every valid output cycle pops one expected pixel.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (v2 && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_word(), 64'hdead);
                end else begin
                    check($sformatf("pix%0d", tag_q.pop_front()), out_word(), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive(input int h, input int v, input logic [11:0] rgb, input logic [11:0] exp_rgb);
        @(negedge clk);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = (h >= HOR_PIXELS);
        vin.vblnk  = (v >= VER_PIXELS);
        vin.hsync  = vin.hcount[0];
        vin.vsync  = vin.vcount[1];
        vin.rgb    = rgb;
        drv_valid  = 1'b1;
        exp_q.push_back({vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, exp_rgb});
        tag_q.push_back(tag_cnt);
        tag_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drv_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        idle(1);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // Active row end in hblank, then the first vblank pixel: a vblnk rising edge.
    task automatic frame_start();
        drive(1100, 767, 12'hfff, 12'h000);
        drive(0, 768, 12'hfff, 12'h000);
    endtask

`ifdef DRAW_PLAYER_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h5fd;
        repeat (3) @(negedge clk);
        check("reset_out", out_word(), 64'd0);
        check("reset_addr", 64'(pixel_addr), 64'd0);
        rst = 1'b0;

        // Before any vblnk rise: pure pass-through, address untouched.
        drive(100, 50, 12'h5fd, 12'h5fd);
        drive(147, 113, 12'h123, 12'h123);
        drive(1030, 50, 12'habc, 12'h000);
        drive(120, 60, 12'habc, 12'habc);
        drain();
        check("addr_before_vblnk", 64'(pixel_addr), 64'd0);

        // Sprite at (100,50).
        frame_start();
        drive(100, 50, 12'h5fd, 12'h000);
        drive(147, 50, 12'h5fd, 12'h02f);
        drive(100, 51, 12'h5fd, 12'h030);
        drive(147, 113, 12'h5fd, 12'hbff);
        drive(99, 50, 12'h5fd, 12'h5fd);
        drive(148, 50, 12'h5fd, 12'h5fd);
        drive(100, 49, 12'h5fd, 12'h5fd);
        drive(100, 114, 12'h5fd, 12'h5fd);
        drive(105, 55, 12'h5fd, TRANSP ? 12'h5fd : 12'h0f0);
        drive(100, 55, 12'habc, TRANSP ? 12'habc : 12'h0f0);
        drive(101, 55, 12'habc, 12'h0f1);
        xpos = 11'd300;
        drive(100, 200, 12'h777, 12'h777);
        drive(100, 100, 12'h5fd, 12'h960);
        drive(300, 100, 12'h777, 12'h777);

        // Next frame picks up xpos=300.
        frame_start();
        drive(300, 100, 12'h5fd, 12'h960);
        drive(100, 100, 12'h777, 12'h777);
        drive(347, 50, 12'habc, 12'h02f);

        // Right-edge clipping, no wrap to column 0 / row 0.
        xpos = 11'(HOR_PIXELS - 10);
        ypos = 11'd0;
        frame_start();
        drive(1014, 0, 12'h5fd, 12'h000);
        drive(1023, 0, 12'h5fd, 12'h009);
        drive(1024, 0, 12'h5fd, 12'h000);
        drive(1061, 0, 12'h5fd, 12'h000);
        drive(0, 0, 12'h5fd, 12'h5fd);
        drive(1013, 0, 12'h5fd, 12'h5fd);
        drive(1014, 63, 12'h5fd, 12'hbd0);
        drive(1014, 64, 12'h5fd, 12'h5fd);
        drive(1014, 767, 12'habc, 12'habc);
        drive(1014, 768, 12'habc, 12'h000);

        // Position near 2047: 11-bit sums would wrap into low columns/rows.
        xpos = 11'd2040;
        ypos = 11'd2000;
        frame_start();
        drive(5, 0, 12'h5fd, 12'h5fd);
        drive(39, 10, 12'h5fd, 12'h5fd);
        drive(5, 10, 12'h5fd, 12'h5fd);

        // Reset mid-frame at (500,300).
        xpos = 11'd100;
        ypos = 11'd50;
        frame_start();
        drive(110, 60, 12'h5fd, 12'h1ea);
        drive(500, 300, 12'habc, 12'habc);
        drain();
        check("pre_reset_out", out_word(), 64'({11'd500, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'habc}));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_out", out_word(), 64'd0);
        check("async_reset_addr", 64'(pixel_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("held_reset_out", out_word(), 64'd0);
        rst = 1'b0;
        drive(100, 50, 12'h5fd, 12'h5fd);
        drive(110, 60, 12'habc, 12'habc);
        frame_start();
        drive(100, 50, 12'h5fd, 12'h000);
        drive(110, 60, 12'h5fd, 12'h1ea);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
